// File: rtl/cpu_6502_alu_pipe.sv
`timescale 1ns/1ps
// cpu_6502_alu_pipe
// 6502-style ALU behind a one-deep valid/ready output register.
// Binary operations complete in one cycle. Decimal ADC/SBC walks one BCD
// nibble per cycle, starting at the LSB, before presenting the result.
//
// Ports
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_valid / o_ready    operation handshake
//   i_func               opcode (AND EOR ORA BIT ADC AD1 SBC SB1 ASL LSR ROL ROR
//                        BYPASS CMP Q_F NOP)
//   i_left, i_right      operands
//   i_c, i_d             carry-in, decimal-mode flag
//   i_flush              synchronous abort of everything in flight or held
//   o_valid / i_ready    result handshake
//   o_q, o_c/o_z/o_v/o_n registered result and flags
module cpu_6502_alu_pipe #(
  parameter int WIDTH  = 8,
  parameter bit DEC_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_func,
  input  logic [WIDTH-1:0] i_left,
  input  logic [WIDTH-1:0] i_right,
  input  logic             i_c,
  input  logic             i_d,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  output logic             o_c,
  output logic             o_z,
  output logic             o_v,
  output logic             o_n
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = $clog2(NIB) + 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] F_AND = 4'h0, F_EOR = 4'h1, F_ORA = 4'h2, F_BIT = 4'h3,
                         F_ADC = 4'h4, F_AD1 = 4'h5, F_SBC = 4'h6, F_SB1 = 4'h7,
                         F_ASL = 4'h8, F_LSR = 4'h9, F_ROL = 4'hA, F_ROR = 4'hB,
                         F_BYP = 4'hC, F_CMP = 4'hD, F_QF  = 4'hE, F_NOP = 4'hF;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, OUT = 2'd2} state_t;

  // Returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add_nib(input logic [3:0] l, input logic [3:0] r,
                                             input logic cin);
    logic [4:0] s;
    s = {1'b0, l} + {1'b0, r} + {4'b0000, cin};
    if (s > 5'd9) bcd_add_nib = {1'b1, s[3:0] + 4'd6};
    else          bcd_add_nib = {1'b0, s[3:0]};
  endfunction

  // Returns {borrow_out, digit}.
  function automatic logic [4:0] bcd_sub_nib(input logic [3:0] l, input logic [3:0] r,
                                             input logic bin);
    logic signed [5:0] d;
    d = $signed({2'b00, l}) - $signed({2'b00, r}) - $signed({5'b00000, bin});
    if (d < 0) bcd_sub_nib = {1'b1, d[3:0] - 4'd6};
    else       bcd_sub_nib = {1'b0, d[3:0]};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             c_q, c_d, v_q, v_d;
  // Decimal working registers. left_q doubles as the result accumulator:
  // each step consumes its low nibble and shifts the new digit in at the top.
  logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic             sub_q, sub_d;
  logic             chain_q, chain_d;   // carry (ADC) or borrow (SBC) between nibbles
  logic             vdec_q, vdec_d;     // binary-mode overflow captured at accept
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept, dec_op;
  logic [WIDTH:0]   sum_w, dif_w, cmp_w;
  logic [WIDTH-1:0] bin_q;
  logic             bin_c, bin_v;
  logic [4:0]       nib_w;

  assign o_ready = ((state_q == IDLE) || ((state_q == OUT) && i_ready)) && !i_flush;
  assign accept  = i_valid && o_ready;
  assign dec_op  = DEC_EN && i_d && ((i_func == F_ADC) || (i_func == F_SBC));

  always_comb begin
    sum_w = {1'b0, i_left} + {1'b0, i_right} + {{WIDTH{1'b0}}, i_c};
    dif_w = {1'b0, i_left} - {1'b0, i_right} - {{WIDTH{1'b0}}, ~i_c};
    cmp_w = {1'b0, i_left} - {1'b0, i_right};
    bin_q = '0;
    bin_c = 1'b0;
    bin_v = 1'b0;
    case (i_func)
      F_AND: bin_q = i_left & i_right;
      F_EOR: bin_q = i_left ^ i_right;
      F_ORA: bin_q = i_left | i_right;
      F_BIT: begin
        bin_q = i_left & i_right;
        bin_v = bin_q[WIDTH-2];
      end
      F_ADC: begin
        bin_q = sum_w[WIDTH-1:0];
        bin_c = sum_w[WIDTH];
        bin_v = ~(i_left[MSB] ^ i_right[MSB]) & (i_left[MSB] ^ sum_w[MSB]);
      end
      F_AD1: bin_q = i_left + {{(WIDTH-1){1'b0}}, 1'b1};
      F_SBC: begin
        // Carry out is the borrow bit of the extended difference.
        bin_q = dif_w[WIDTH-1:0];
        bin_c = dif_w[WIDTH];
        bin_v = (i_left[MSB] ^ dif_w[MSB]) & (i_left[MSB] ^ i_right[MSB]);
      end
      F_SB1: bin_q = i_left - {{(WIDTH-1){1'b0}}, 1'b1};
      F_ASL: begin
        bin_q = {i_left[WIDTH-2:0], 1'b0};
        bin_c = i_left[MSB];
      end
      F_LSR: begin
        bin_q = {1'b0, i_left[WIDTH-1:1]};
        bin_c = i_left[0];
      end
      F_ROL: begin
        bin_q = {i_left[WIDTH-2:0], i_c};
        bin_c = i_left[MSB];
      end
      F_ROR: begin
        bin_q = {i_c, i_left[WIDTH-1:1]};
        bin_c = i_left[0];
      end
      F_BYP: bin_q = i_left;
      F_CMP: begin
        bin_q = cmp_w[WIDTH-1:0];
        bin_c = cmp_w[WIDTH];
      end
      F_QF:  bin_q = '1;
      F_NOP: bin_q = '0;
      default: bin_q = '0;
    endcase
  end

  always_comb begin
    if (sub_q) nib_w = bcd_sub_nib(left_q[3:0], right_q[3:0], chain_q);
    else       nib_w = bcd_add_nib(left_q[3:0], right_q[3:0], chain_q);
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    c_d     = c_q;
    v_d     = v_q;
    left_d  = left_q;
    right_d = right_q;
    sub_d   = sub_q;
    chain_d = chain_q;
    vdec_d  = vdec_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, OUT: begin
          if (accept) begin
            if (dec_op) begin
              state_d = BUSY;
              left_d  = i_left;
              right_d = i_right;
              sub_d   = (i_func == F_SBC);
              chain_d = (i_func == F_SBC) ? ~i_c : i_c;
              vdec_d  = bin_v;
              cnt_d   = '0;
            end else begin
              state_d = OUT;
              q_d     = bin_q;
              c_d     = bin_c;
              v_d     = bin_v;
            end
          end else if ((state_q == OUT) && i_ready) begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          left_d  = {nib_w[3:0], left_q[WIDTH-1:4]};
          right_d = {4'b0000, right_q[WIDTH-1:4]};
          chain_d = nib_w[4];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NIB - 1)) begin
            state_d = OUT;
            q_d     = {nib_w[3:0], left_q[WIDTH-1:4]};
            c_d     = nib_w[4];
            v_d     = vdec_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      sub_q   <= 1'b0;
      chain_q <= 1'b0;
      vdec_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      c_q     <= c_d;
      v_q     <= v_d;
      left_q  <= left_d;
      right_q <= right_d;
      sub_q   <= sub_d;
      chain_q <= chain_d;
      vdec_q  <= vdec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid = (state_q == OUT);
  assign o_q     = q_q;
  assign o_c     = c_q;
  assign o_v     = v_q;
  assign o_z     = (q_q == '0);
  assign o_n     = q_q[MSB];

endmodule

// File: tb/tb_cpu_6502_alu_pipe.sv
`timescale 1ns/1ps
module tb_cpu_6502_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, i_c, i_d, i_flush, i_ready;
  logic [3:0] i_func;
  logic [7:0] i_left, i_right;
  logic       o_ready, o_valid, o_c, o_z, o_v, o_n;
  logic [7:0] o_q;

  logic        v16, c16, d16, ir16, fl16;
  logic [3:0]  f16;
  logic [15:0] l16, r16;
  logic        rdy16, val16, oc16, oz16, ov16, on16;
  logic [15:0] q16;

  always #5 clk = ~clk;

  cpu_6502_alu_pipe #(.WIDTH(8), .DEC_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_func(i_func), .i_left(i_left), .i_right(i_right), .i_c(i_c), .i_d(i_d),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_q(o_q),
    .o_c(o_c), .o_z(o_z), .o_v(o_v), .o_n(o_n)
  );

  cpu_6502_alu_pipe #(.WIDTH(16), .DEC_EN(1'b1)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(rdy16),
    .i_func(f16), .i_left(l16), .i_right(r16), .i_c(c16), .i_d(d16),
    .i_flush(fl16), .o_valid(val16), .i_ready(ir16), .o_q(q16),
    .o_c(oc16), .o_z(oz16), .o_v(ov16), .o_n(on16)
  );

  typedef struct packed {
    logic [15:0] q;
    logic        c;
    logic        v;
  } res_t;

  int n_chk  = 0;
  int n_fail = 0;
  logic [11:0] sb[$];   // {q, c, v, n, z}

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: plain integer arithmetic over the operation rules.
  function automatic res_t model(int w, logic [3:0] f, int l, int r, bit c, bit d);
    res_t o;
    int mask, msb, s, q, dig, cy, ln, rn;
    mask = (1 << w) - 1;
    msb  = w - 1;
    q    = 0;
    o.c  = 1'b0;
    o.v  = 1'b0;
    case (f)
      4'h0: q = l & r;
      4'h1: q = l ^ r;
      4'h2: q = l | r;
      4'h3: begin q = l & r; o.v = ((q >> (w - 2)) & 1) != 0; end
      4'h4: begin
        s = l + r + int'(c);
        q = s & mask;
        o.c = (s > mask);
        o.v = ((((~(l ^ r)) & (l ^ q)) >> msb) & 1) != 0;
        if (d) begin
          cy = int'(c);
          q  = 0;
          for (int k = 0; k < w / 4; k++) begin
            ln = (l >> (4 * k)) & 15;
            rn = (r >> (4 * k)) & 15;
            s  = ln + rn + cy;
            if (s > 9) begin dig = (s + 6) % 16; cy = 1; end
            else       begin dig = s;            cy = 0; end
            q = q | (dig << (4 * k));
          end
          o.c = (cy != 0);
        end
      end
      4'h5: q = (l + 1) & mask;
      4'h6: begin
        s = l - r - (c ? 0 : 1);
        q = s & mask;
        o.c = (s < 0);
        o.v = ((((l ^ q) & (l ^ r)) >> msb) & 1) != 0;
        if (d) begin
          cy = c ? 0 : 1;
          q  = 0;
          for (int k = 0; k < w / 4; k++) begin
            ln = (l >> (4 * k)) & 15;
            rn = (r >> (4 * k)) & 15;
            s  = ln - rn - cy;
            if (s < 0) begin dig = (s - 6) & 15; cy = 1; end
            else       begin dig = s;            cy = 0; end
            q = q | (dig << (4 * k));
          end
          o.c = (cy != 0);
        end
      end
      4'h7: q = (l - 1) & mask;
      4'h8: begin q = (l << 1) & mask; o.c = ((l >> msb) & 1) != 0; end
      4'h9: begin q = l >> 1;          o.c = (l & 1) != 0; end
      4'hA: begin q = ((l << 1) | int'(c)) & mask; o.c = ((l >> msb) & 1) != 0; end
      4'hB: begin q = (l >> 1) | (c ? (1 << msb) : 0); o.c = (l & 1) != 0; end
      4'hC: q = l;
      4'hD: begin s = l - r; q = s & mask; o.c = (s < 0); end
      4'hE: q = mask;
      default: q = 0;
    endcase
    o.q = 16'(q);
    return o;
  endfunction

  function automatic logic [11:0] pack8(res_t m);
    return {m.q[7:0], m.c, m.v, m.q[7], (m.q[7:0] == 8'h00)};
  endfunction

  // Monitor: compares each result at the moment the consumer takes it.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst && o_valid && i_ready && !i_flush) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got q=%0h with no result outstanding", o_q);
      end else begin
        e = sb.pop_front();
        chk("result", 32'({o_q, o_c, o_v, o_n, o_z}), 32'(e));
      end
    end
  end

  // Offers one operation; starts and ends 1ns after a rising edge.
  task automatic issue(input logic [3:0] f, input logic [7:0] l, input logic [7:0] r,
                       input bit c, input bit d, input bit rnd, input bit push);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    i_valid = 1'b1; i_func = f; i_left = l; i_right = r; i_c = c; i_d = d;
    while (!acc && guard < 100) begin
      i_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (o_ready) begin
        acc = 1'b1;
        if (push) sb.push_back(pack8(model(8, f, int'(l), int'(r), c, d)));
      end
      guard++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: op %0h not accepted, got o_ready=0, expected 1", f);
    end
  endtask

  // Counts falling edges until o_valid; ends on the falling edge where it is seen.
  task automatic wait_valid(input int exp_lat, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!o_valid) chk({nm, "_busy_ready"}, 32'(o_ready), 0);
    end while (!o_valid && n < 20);
    chk({nm, "_latency"}, n, exp_lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_ready = 1'b1;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    i_valid = 0; i_func = 0; i_left = 0; i_right = 0; i_c = 0; i_d = 0;
    i_flush = 0; i_ready = 1;
    v16 = 0; f16 = 0; l16 = 0; r16 = 0; c16 = 0; d16 = 0; ir16 = 1; fl16 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_q", 32'(o_q), 0);
    chk("rst_c", 32'(o_c), 0);
    chk("rst_v", 32'(o_v), 0);
    chk("rst_z", 32'(o_z), 1);
    chk("rst_n", 32'(o_n), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(o_ready), 1);
    @(posedge clk); #1;

    // Binary ADC with signed overflow
    issue(4'h4, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_valid(1, "adc_bin");
    chk("adc_bin_q", 32'(o_q), 'hA0);
    chk("adc_bin_c", 32'(o_c), 0);
    chk("adc_bin_v", 32'(o_v), 1);
    chk("adc_bin_n", 32'(o_n), 1);
    chk("adc_bin_z", 32'(o_z), 0);
    @(posedge clk); #1;

    // Decimal ADC
    issue(4'h4, 8'h58, 8'h46, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_valid(3, "adc_dec");
    chk("adc_dec_q", 32'(o_q), 'h05);
    chk("adc_dec_c", 32'(o_c), 1);
    @(posedge clk); #1;

    // Decimal SBC, without and with borrow
    issue(4'h6, 8'h46, 8'h12, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_valid(3, "sbc_dec_a");
    chk("sbc_dec_a_q", 32'(o_q), 'h34);
    chk("sbc_dec_a_c", 32'(o_c), 0);
    @(posedge clk); #1;
    issue(4'h6, 8'h12, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_valid(3, "sbc_dec_b");
    chk("sbc_dec_b_q", 32'(o_q), 'h91);
    chk("sbc_dec_b_c", 32'(o_c), 1);
    @(posedge clk); #1;

    // CMP held under back-pressure, then back-to-back ASL
    issue(4'hD, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    i_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("hold_valid", 32'(o_valid), 1);
      chk("hold_q", 32'(o_q), 'hF0);
      chk("hold_c", 32'(o_c), 1);
      chk("hold_n", 32'(o_n), 1);
      chk("hold_ready", 32'(o_ready), 0);
    end
    @(posedge clk); #1;
    issue(4'h8, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_valid(1, "asl_b2b");
    chk("asl_q", 32'(o_q), 'h02);
    chk("asl_c", 32'(o_c), 1);
    @(posedge clk); #1;
    drain();

    // Flush during a decimal operation
    issue(4'h4, 8'h99, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
    i_flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", 32'(o_ready), 0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_valid", 32'(o_valid), 0);
    chk("flush_busy_ready", 32'(o_ready), 1);
    repeat (4) begin
      @(negedge clk);
      chk("flush_busy_no_stale", 32'(o_valid), 0);
    end
    @(posedge clk); #1;

    // Flush of a held result
    issue(4'hE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    i_ready = 1'b0;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_out_no_stale", 32'(o_valid), 0);
    end
    @(posedge clk); #1;

    // Reset during a decimal operation
    issue(4'h6, 8'h55, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy_valid", 32'(o_valid), 0);
    chk("rst_busy_q", 32'(o_q), 0);
    chk("rst_busy_z", 32'(o_z), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_ready", 32'(o_ready), 1);
    chk("rst_busy_valid_after", 32'(o_valid), 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_busy_no_stale", 32'(o_valid), 0);
    end
    @(posedge clk); #1;

    // WIDTH=16 decimal ADC with full carry ripple
    v16 = 1'b1; f16 = 4'h4; l16 = 16'h9999; r16 = 16'h0001; c16 = 1'b0; d16 = 1'b1;
    @(negedge clk);
    chk("w16_accept_ready", 32'(rdy16), 1);
    @(posedge clk); #1;
    v16 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!val16 && n < 20);
    chk("w16_latency", n, 5);
    chk("w16_q", 32'(q16), 'h0000);
    chk("w16_c", 32'(oc16), 1);
    chk("w16_z", 32'(oz16), 1);
    @(posedge clk); #1;

    // Randomized traffic with random back-pressure and idle gaps
    for (int i = 0; i < 400; i++) begin
      issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        i_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
